// File: rtl/hier_node_pkg.sv
// Shared sizing helpers and constants for hierarchical dispatch nodes.
package hier_node_pkg;

  localparam int DROP_CNT_W = 16;

  // One extra code beyond the child range keeps the all-ones code always invalid.
  function automatic int dest_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [31:0] bcast_code(input int n);
    return (32'd1 << dest_w(n)) - 32'd1;
  endfunction

endpackage

// File: rtl/hier_dispatch_node_if.sv
// Parent-side input stream and per-child output streams of a dispatch node.
interface hier_dispatch_node_if
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 32,
  parameter int DEST_W       = dest_w(NUM_CHILDREN)
);
  logic                                in_valid;
  logic                                in_ready;
  logic [DEST_W-1:0]                   in_dest;
  logic [DATA_W-1:0]                   in_data;
  logic [NUM_CHILDREN-1:0]             out_valid;
  logic [NUM_CHILDREN-1:0]             out_ready;
  logic [NUM_CHILDREN-1:0][DATA_W-1:0] out_data;
  logic                                err_dest;
  logic [DROP_CNT_W-1:0]               drop_cnt;

  modport master (
    output in_valid, in_dest, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_dest, drop_cnt
  );

  modport slave (
    input  in_valid, in_dest, in_data, out_ready,
    output in_ready, out_valid, out_data, err_dest, drop_cnt
  );
endinterface

// File: rtl/hier_child_fifo.sv
// Per-child FIFO: power-of-two depth, no bypass, head zeroed while empty.
module hier_child_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage carries no reset; the count alone decides what is live.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/hier_dispatch_node.sv
// Routes one tagged input stream into NUM_CHILDREN independent FIFOs.
// Define HIER_DISPATCH_BCAST_EN to treat the all-ones destination as broadcast.
module hier_dispatch_node
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4
)(
  input  logic                 clk,
  input  logic                 rst,
  hier_dispatch_node_if.slave  bus
);
  localparam int DEST_W = dest_w(NUM_CHILDREN);

  logic [NUM_CHILDREN-1:0]             full, empty, push;
  logic [NUM_CHILDREN-1:0][DATA_W-1:0] head;
  logic                                dest_ok, is_bcast, sel_full, ready, accept, drop;
  logic                                err_q;
  logic [DROP_CNT_W-1:0]               cnt_q;

  assign dest_ok = int'(bus.in_dest) < NUM_CHILDREN;

`ifdef HIER_DISPATCH_BCAST_EN
  localparam logic [DEST_W-1:0] BCAST = DEST_W'(bcast_code(NUM_CHILDREN));
  assign is_bcast = (bus.in_dest == BCAST);
`else
  assign is_bcast = 1'b0;
`endif

  // Ready depends only on the destination and full flags, never on out_ready.
  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NUM_CHILDREN; i++)
      if (bus.in_dest == DEST_W'(i)) sel_full = full[i];
    ready = ~sel_full;
    if (is_bcast) ready = ~|full;
  end

  assign accept = bus.in_valid & ready;
  assign drop   = accept & ~dest_ok & ~is_bcast;

  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_CHILDREN; i++)
      push[i] = accept & (is_bcast | (dest_ok & (bus.in_dest == DEST_W'(i))));
  end

  for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_child
    hier_child_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (bus.in_data),
      .pop       (bus.out_ready[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head_data (head[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= drop;
      if (drop && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = head;
  assign bus.err_dest  = err_q;
  assign bus.drop_cnt  = cnt_q;
endmodule

// File: tb/tb_hier_dispatch_node.sv
// Directed bench for hier_dispatch_node with five children, 32-bit data, depth 4.
module tb_hier_dispatch_node;
  localparam int NC = 5, DW = 32, DEP = 4, DESTW = 3;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  int   drops = 0;

  always #5 clk = ~clk;

  hier_dispatch_node_if #(.NUM_CHILDREN(NC), .DATA_W(DW), .DEST_W(DESTW)) bus ();

  hier_dispatch_node #(.NUM_CHILDREN(NC), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_dest = '0; bus.in_data = '0; bus.out_ready = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    bus.in_valid = 1'b1;
    bus.in_dest = 3'd0; bus.in_data = 32'h11; tick;
    bus.in_dest = 3'd3; bus.in_data = 32'h33; tick;
    bus.in_dest = 3'd5; tick;
    bus.in_valid = 1'b0; bus.in_dest = 3'd0;
    vecs++; if (bus.out_valid !== 5'b01001) begin errs++; $display("FAIL pre_rst_valid got %b want %b", bus.out_valid, 5'b01001); end
    vecs++; if (bus.drop_cnt !== 16'd1) begin errs++; $display("FAIL pre_rst_drop got %0d want 1", bus.drop_cnt); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (bus.out_valid !== 5'b00000) begin errs++; $display("FAIL rst_valid got %b want 00000", bus.out_valid); end
    vecs++; if (bus.out_data !== '0) begin errs++; $display("FAIL rst_data got %h want 0", bus.out_data); end
    vecs++; if (bus.drop_cnt !== 16'd0) begin errs++; $display("FAIL rst_drop got %0d want 0", bus.drop_cnt); end
    vecs++; if (bus.err_dest !== 1'b0) begin errs++; $display("FAIL rst_err got %b want 0", bus.err_dest); end
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick;
    bus.in_valid = 1'b1; bus.in_dest = 3'd2; bus.in_data = 32'hCAFE0001;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL route_ready got %b want 1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== 5'b00100) begin errs++; $display("FAIL route_valid got %b want 00100", bus.out_valid); end
    vecs++; if (bus.out_data[2] !== 32'hCAFE0001) begin errs++; $display("FAIL route_data got %h want CAFE0001", bus.out_data[2]); end
  endtask

  task automatic test_backpressure;
    logic [31:0] a [5];
    int idx;
    logic acc;
    for (int k = 0; k < 5; k++) a[k] = 32'hA0000000 + k;
    bus.out_ready = 5'b11101;
    tick;
    vecs++; if (bus.out_valid !== 5'b00000) begin errs++; $display("FAIL bp_idle got %b want 00000", bus.out_valid); end
    bus.in_valid = 1'b1; bus.in_dest = 3'd1;
    for (int k = 0; k < 4; k++) begin
      bus.in_data = a[k];
      vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bp_fill_ready[%0d] got %b want 1", k, bus.in_ready); end
      tick;
    end
    bus.in_data = a[4];
    for (int k = 0; k < 2; k++) begin
      vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL bp_full_ready[%0d] got %b want 0", k, bus.in_ready); end
      vecs++; if (bus.out_data[1] !== a[0]) begin errs++; $display("FAIL bp_held_head got %h want %h", bus.out_data[1], a[0]); end
      tick;
    end
    bus.out_ready[1] = 1'b1;
    idx = 0;
    for (int c = 0; c < 12 && idx < 5; c++) begin
      if (bus.out_valid[1]) begin
        vecs++; if (bus.out_data[1] !== a[idx]) begin errs++; $display("FAIL bp_drain[%0d] got %h want %h", idx, bus.out_data[1], a[idx]); end
        idx++;
      end
      acc = bus.in_valid & bus.in_ready;
      tick;
      if (acc) bus.in_valid = 1'b0;
    end
    vecs++; if (idx != 5) begin errs++; $display("FAIL bp_drain_count got %0d want 5", idx); end
    vecs++; if (bus.out_valid !== 5'b00000) begin errs++; $display("FAIL bp_empty got %b want 00000", bus.out_valid); end
  endtask

  task automatic test_simul_push_pop;
    logic [31:0] b [10];
    logic [31:0] tail [4];
    for (int k = 0; k < 10; k++) b[k] = 32'hB0000000 + k;
    bus.out_ready = 5'b11110;
    bus.in_valid = 1'b1; bus.in_dest = 3'd0;
    bus.in_data = b[0]; tick;
    bus.in_data = b[1]; tick;
    bus.out_ready[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      bus.in_data = b[j+2];
      vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL pp_ready[%0d] got %b want 1", j, bus.in_ready); end
      vecs++; if (bus.out_data[0] !== b[j]) begin errs++; $display("FAIL pp_head[%0d] got %h want %h", j, bus.out_data[0], b[j]); end
      tick;
    end
    // Two more pushes with the pop stalled must fill the FIFO if count held at 2.
    bus.out_ready[0] = 1'b0;
    bus.in_data = 32'hC0000000; tick;
    bus.in_data = 32'hC0000001; tick;
    bus.in_valid = 1'b0;
    vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL pp_full got %b want 0", bus.in_ready); end
    tail[0] = b[8]; tail[1] = b[9]; tail[2] = 32'hC0000000; tail[3] = 32'hC0000001;
    bus.out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vecs++; if (bus.out_data[0] !== tail[k]) begin errs++; $display("FAIL pp_tail[%0d] got %h want %h", k, bus.out_data[0], tail[k]); end
      tick;
    end
    vecs++; if (bus.out_valid !== 5'b00000) begin errs++; $display("FAIL pp_empty got %b want 00000", bus.out_valid); end
  endtask

  task automatic test_invalid_dest;
    bus.out_ready = 5'b11111;
    bus.in_valid = 1'b1; bus.in_dest = 3'd5; bus.in_data = 32'hDEAD0005;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL inv5_ready got %b want 1", bus.in_ready); end
    tick;
    vecs++; if (bus.err_dest !== 1'b1) begin errs++; $display("FAIL inv5_err got %b want 1", bus.err_dest); end
    bus.in_dest = 3'd6; bus.in_data = 32'hDEAD0006;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL inv6_ready got %b want 1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
    vecs++; if (bus.err_dest !== 1'b1) begin errs++; $display("FAIL inv6_err got %b want 1", bus.err_dest); end
    vecs++; if (bus.drop_cnt !== 16'd2) begin errs++; $display("FAIL inv_drop got %0d want 2", bus.drop_cnt); end
    vecs++; if (bus.out_valid !== 5'b00000) begin errs++; $display("FAIL inv_valid got %b want 00000", bus.out_valid); end
    tick;
    vecs++; if (bus.err_dest !== 1'b0) begin errs++; $display("FAIL inv_err_clear got %b want 0", bus.err_dest); end
    drops = 2;
  endtask

  task automatic test_broadcast;
    bus.in_valid = 1'b1; bus.in_dest = 3'd7; bus.in_data = 32'h5A5A5A5A;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bc_ready got %b want 1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
`ifdef HIER_DISPATCH_BCAST_EN
    vecs++; if (bus.out_valid !== 5'b11111) begin errs++; $display("FAIL bc_valid got %b want 11111", bus.out_valid); end
    for (int i = 0; i < NC; i++) begin
      vecs++; if (bus.out_data[i] !== 32'h5A5A5A5A) begin errs++; $display("FAIL bc_data[%0d] got %h want 5A5A5A5A", i, bus.out_data[i]); end
    end
    vecs++; if (bus.err_dest !== 1'b0) begin errs++; $display("FAIL bc_err got %b want 0", bus.err_dest); end
    vecs++; if (bus.drop_cnt !== 16'd2) begin errs++; $display("FAIL bc_drop got %0d want 2", bus.drop_cnt); end
    tick;
    bus.out_ready = 5'b10111;
    bus.in_valid = 1'b1; bus.in_dest = 3'd3;
    for (int k = 0; k < 4; k++) begin bus.in_data = 32'h30 + k; tick; end
    bus.in_valid = 1'b0; bus.in_dest = 3'd7;
    vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL bc_blocked got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_dest = 3'd0; bus.in_data = 32'h0D;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bc_dest0_ready got %b want 1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== 5'b01001) begin errs++; $display("FAIL bc_dest0_valid got %b want 01001", bus.out_valid); end
    vecs++; if (bus.out_data[0] !== 32'h0D) begin errs++; $display("FAIL bc_dest0_data got %h want 0000000d", bus.out_data[0]); end
    bus.out_ready = 5'b11111;
    tick; tick; tick; tick;
    vecs++; if (bus.out_valid !== 5'b00000) begin errs++; $display("FAIL bc_drained got %b want 00000", bus.out_valid); end
`else
    vecs++; if (bus.out_valid !== 5'b00000) begin errs++; $display("FAIL bc_valid got %b want 00000", bus.out_valid); end
    vecs++; if (bus.err_dest !== 1'b1) begin errs++; $display("FAIL bc_err got %b want 1", bus.err_dest); end
    vecs++; if (bus.drop_cnt !== 16'd3) begin errs++; $display("FAIL bc_drop got %0d want 3", bus.drop_cnt); end
    drops = 3;
`endif
  endtask

  task automatic test_drop_saturation;
    bus.in_valid = 1'b1; bus.in_dest = 3'd6; bus.in_data = 32'hFFFF0000;
    for (int k = drops; k < 65535; k++) tick;
    vecs++; if (bus.drop_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_reach got %h want ffff", bus.drop_cnt); end
    tick; tick;
    bus.in_valid = 1'b0;
    vecs++; if (bus.drop_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_hold got %h want ffff", bus.drop_cnt); end
    vecs++; if (bus.err_dest !== 1'b1) begin errs++; $display("FAIL sat_err got %b want 1", bus.err_dest); end
    vecs++; if (bus.out_valid !== 5'b00000) begin errs++; $display("FAIL sat_valid got %b want 00000", bus.out_valid); end
  endtask

  initial begin
    test_reset;
    test_backpressure;
    test_simul_push_pop;
    test_invalid_dest;
    test_broadcast;
    test_drop_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
